// File: rtl/winocnn_pkg.sv
// Shared constants, tile types and FSM encoding for the Winograd PE accumulation stage.
// Flat tile ports use element k = i*TILE + j, matching the packed [i][j] layout of the typedefs.
package winocnn_pkg;

    localparam int TILE           = 6;
    localparam int TILE_ELEMS     = TILE * TILE;
    localparam int DEF_MAX_BLOCKS = 16;
    localparam int DEF_DATA_W     = 14;
    localparam int DEF_WGT_W      = 12;
    localparam int DEF_ACC_W      = 32;

    localparam logic [7:0] ADDR_EMPTY = 8'hFF;

    typedef logic [TILE-1:0][TILE-1:0][DEF_DATA_W-1:0]             in_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][DEF_WGT_W-1:0]              wgt_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][DEF_DATA_W+DEF_WGT_W-1:0]   prod_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][DEF_ACC_W-1:0]              acc_tile_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } acc_state_e;

    // Global block address -> block index within the current channel plane (wraps at 8 bits).
    function automatic logic [7:0] local_index(input logic [7:0] addr,
                                               input logic [7:0] block_cnt,
                                               input logic [3:0] input_id);
        return addr - block_cnt * {4'd0, input_id};
    endfunction

endpackage

// File: rtl/pe_tile_mul.sv
// Stage 1: registered element-wise signed multiply of one input tile by the weight tile.
// Carries the lane's block index and valid alongside the products.
module pe_tile_mul
    import winocnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WGT_W  = DEF_WGT_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic [7:0]                             in_idx,
    input  logic [TILE_ELEMS*DATA_W-1:0]           tile,
    input  logic [TILE_ELEMS*WGT_W-1:0]            weight,
    output logic [TILE_ELEMS*(DATA_W+WGT_W)-1:0]   prod,
    output logic [7:0]                             out_idx,
    output logic                                   out_valid
);

    localparam int PROD_W = DATA_W + WGT_W;

    logic [TILE_ELEMS*PROD_W-1:0] prod_c;

    always_comb begin
        prod_c = '0;
        for (int k = 0; k < TILE_ELEMS; k++) begin
            prod_c[k*PROD_W +: PROD_W] = PROD_W'($signed(tile[k*DATA_W +: DATA_W]))
                                       * PROD_W'($signed(weight[k*WGT_W +: WGT_W]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod      <= '0;
            out_idx   <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                prod    <= prod_c;
                out_idx <= in_idx;
            end
        end
    end

endmodule

// File: rtl/pe_tile_accumulator.sv
// Two-lane tile MAC into a per-block accumulator bank, drained one 6x6 sum per block
// over valid/ready after a two-cycle pipeline flush.
module pe_tile_accumulator
    import winocnn_pkg::*;
#(
    parameter int MAX_BLOCKS = DEF_MAX_BLOCKS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WGT_W      = DEF_WGT_W,
    parameter int ACC_W      = DEF_ACC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    block_cnt_i,
    input  logic [3:0]                    input_id_i,
    input  logic [TILE_ELEMS*DATA_W-1:0]  tile_i_1,
    input  logic [TILE_ELEMS*DATA_W-1:0]  tile_i_2,
    input  logic [7:0]                    addr_i_1,
    input  logic [7:0]                    addr_i_2,
    input  logic                          data_valid_i,
    input  logic [TILE_ELEMS*WGT_W-1:0]   weight_tile_i,
    input  logic                          drain_start_i,
    output logic [TILE_ELEMS*ACC_W-1:0]   acc_tile_o,
    output logic [7:0]                    acc_idx_o,
    output logic                          acc_valid_o,
    input  logic                          acc_ready_i,
    output logic                          drain_done_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [1:0]                    dbg_state
);

    // Drain handshake: a tile transfers on a rising edge where acc_valid_o && acc_ready_i;
    // acc_tile_o/acc_idx_o stay stable while acc_valid_o is high and acc_ready_i is low.

    localparam int PROD_W = DATA_W + WGT_W;
    localparam int IW     = $clog2(MAX_BLOCKS);
    localparam int TILE_W = TILE_ELEMS * ACC_W;

    acc_state_e state, state_n;
    logic       flush_cnt, flush_cnt_n;
    logic [7:0] drain_idx, drain_idx_n;
    logic       done_n, clear_valid;

    logic [7:0] idx_1, idx_2;
    logic       in_range_1, in_range_2;
    logic       lane_ok_1, lane_ok_2;
    logic       err_set;

    logic [TILE_ELEMS*PROD_W-1:0] prod_1, prod_2;
    logic [7:0]                   pidx_1, pidx_2;
    logic                         pval_1, pval_2;

    logic [TILE_W-1:0]     ext_1, ext_2;
    logic [MAX_BLOCKS-1:0] hit_1, hit_2, entry_valid;
    logic [TILE_W-1:0]     bank [MAX_BLOCKS];

    logic [IW-1:0] drain_sel;
    logic          drain_in_bank;

    always_comb begin
        idx_1      = local_index(addr_i_1, block_cnt_i, input_id_i);
        idx_2      = local_index(addr_i_2, block_cnt_i, input_id_i);
        in_range_1 = (idx_1 < block_cnt_i) && (32'(idx_1) < MAX_BLOCKS);
        in_range_2 = (idx_2 < block_cnt_i) && (32'(idx_2) < MAX_BLOCKS);
        lane_ok_1  = data_valid_i && (state == ACCUM) && (addr_i_1 != ADDR_EMPTY) && in_range_1;
        lane_ok_2  = data_valid_i && (state == ACCUM) && (addr_i_2 != ADDR_EMPTY) && in_range_2;
        // Anything arriving while busy, or any non-empty lane with a bad index, is lost data.
        err_set    = data_valid_i && ((state != ACCUM)
                   || ((addr_i_1 != ADDR_EMPTY) && !in_range_1)
                   || ((addr_i_2 != ADDR_EMPTY) && !in_range_2));
    end

    pe_tile_mul #(.DATA_W(DATA_W), .WGT_W(WGT_W)) u_mul_1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (lane_ok_1),
        .in_idx    (idx_1),
        .tile      (tile_i_1),
        .weight    (weight_tile_i),
        .prod      (prod_1),
        .out_idx   (pidx_1),
        .out_valid (pval_1)
    );

    pe_tile_mul #(.DATA_W(DATA_W), .WGT_W(WGT_W)) u_mul_2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (lane_ok_2),
        .in_idx    (idx_2),
        .tile      (tile_i_2),
        .weight    (weight_tile_i),
        .prod      (prod_2),
        .out_idx   (pidx_2),
        .out_valid (pval_2)
    );

    always_comb begin
        ext_1 = '0;
        ext_2 = '0;
        hit_1 = '0;
        hit_2 = '0;
        for (int k = 0; k < TILE_ELEMS; k++) begin
            ext_1[k*ACC_W +: ACC_W] = ACC_W'($signed(prod_1[k*PROD_W +: PROD_W]));
            ext_2[k*ACC_W +: ACC_W] = ACC_W'($signed(prod_2[k*PROD_W +: PROD_W]));
        end
        for (int e = 0; e < MAX_BLOCKS; e++) begin
            hit_1[e] = pval_1 && (pidx_1 == 8'(e));
            hit_2[e] = pval_2 && (pidx_2 == 8'(e));
        end
    end

    // Stage 2: single-cycle read-modify-write; both lanes on one entry add together.
    always_ff @(posedge clk) begin
        for (int e = 0; e < MAX_BLOCKS; e++) begin
            if (hit_1[e] || hit_2[e]) begin
                for (int k = 0; k < TILE_ELEMS; k++) begin
                    bank[e][k*ACC_W +: ACC_W] <=
                        (entry_valid[e] ? bank[e][k*ACC_W +: ACC_W] : '0)
                      + (hit_1[e] ? ext_1[k*ACC_W +: ACC_W] : '0)
                      + (hit_2[e] ? ext_2[k*ACC_W +: ACC_W] : '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ACCUM;
            flush_cnt    <= 1'b0;
            drain_idx    <= 8'd0;
            drain_done_o <= 1'b0;
            err_o        <= 1'b0;
            entry_valid  <= '0;
        end else begin
            state        <= state_n;
            flush_cnt    <= flush_cnt_n;
            drain_idx    <= drain_idx_n;
            drain_done_o <= done_n;
            err_o        <= err_o | err_set;
            entry_valid  <= clear_valid ? '0 : (entry_valid | hit_1 | hit_2);
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        drain_idx_n = drain_idx;
        done_n      = 1'b0;
        clear_valid = 1'b0;
        acc_valid_o = 1'b0;
        acc_idx_o   = 8'd0;
        busy_o      = 1'b1;
        case (state)
            ACCUM: begin
                busy_o = 1'b0;
                if (drain_start_i) begin
                    state_n     = FLUSH;
                    flush_cnt_n = 1'b0;
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    drain_idx_n = 8'd0;
                    if (block_cnt_i == 8'd0) begin
                        state_n     = ACCUM;
                        done_n      = 1'b1;
                        clear_valid = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end else begin
                    flush_cnt_n = 1'b1;
                end
            end
            DRAIN: begin
                acc_valid_o = 1'b1;
                acc_idx_o   = drain_idx;
                if (acc_ready_i) begin
                    if (drain_idx == block_cnt_i - 8'd1) begin
                        state_n     = ACCUM;
                        done_n      = 1'b1;
                        clear_valid = 1'b1;
                    end else begin
                        drain_idx_n = drain_idx + 8'd1;
                    end
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    assign dbg_state = state;

    // Indices past the bank (block_cnt_i > MAX_BLOCKS) can never hold data and read as zero.
    always_comb begin
        drain_sel     = drain_idx[IW-1:0];
        drain_in_bank = 32'(drain_idx) < MAX_BLOCKS;
        acc_tile_o    = '0;
        if (acc_valid_o && drain_in_bank && entry_valid[drain_sel]) begin
            acc_tile_o = bank[drain_sel];
        end
    end

endmodule
